// File: rtl/wbwalker_master_if.sv
// Wishbone link between the LED-walker initiator and the walker's slave port.
// Initiator-driven signals carry o_ prefixes; slave-driven ones carry i_.
interface wbwalker_master_if;
  logic       o_cyc;
  logic       o_stb;
  logic       o_we;
  logic       o_addr;
  logic [5:0] o_data;
  logic       i_stall;
  logic       i_ack;
  logic [5:0] i_data;

  modport master (
    output o_cyc, o_stb, o_we, o_addr, o_data,
    input  i_stall, i_ack, i_data
  );

  modport slave (
    input  o_cyc, o_stb, o_we, o_addr, o_data,
    output i_stall, i_ack, i_data
  );
endinterface

// File: rtl/wbwalker_master.sv
// Wishbone initiator: one write (walk start, data = seq) then one read of the LED register per request.
// CYC/STB one cycle after a request; STB holds under stall; any bus state lasting TIMEOUT cycles aborts.
module wbwalker_master #(
  parameter int PERIOD  = 1000,
  parameter int TIMEOUT = 15
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_trigger,
  output logic                    o_busy,
  output logic                    o_err,
  output logic [5:0]              o_rdata,
  wbwalker_master_if.master       wb
);

  localparam int TMR_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(PERIOD - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_ACK,
    RD_REQ,
    RD_ACK
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q;
  logic [TMO_W-1:0] tmo_q;
  logic [5:0]       seq_q;
  logic             pend_q;
  logic             err_q;
  logic [5:0]       rdata_q;
  logic             cyc_q;
  logic             stb_q;
  logic             we_q;
  logic [5:0]       data_q;
  logic             busy_q;

  logic tick;
  logic timeout;
  logic enter_wr;

  assign tick = (timer_q == '0);

  // A state change always wins over the timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pend_q || tick || i_trigger) state_d = WR_REQ;
      WR_REQ:  if (!wb.i_stall)                 state_d = WR_ACK;
      WR_ACK:  if (wb.i_ack)                    state_d = RD_REQ;
      RD_REQ:  if (!wb.i_stall)                 state_d = RD_ACK;
      RD_ACK:  if (wb.i_ack)                    state_d = IDLE;
      default:                                  state_d = IDLE;
    endcase
    timeout = (state_q != IDLE) && (state_d == state_q) && (tmo_q == TMO_LAST);
    if (timeout) state_d = IDLE;
  end

  assign enter_wr = (state_q == IDLE) && (state_d == WR_REQ);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      timer_q <= TMR_INIT;
      tmo_q   <= '0;
      seq_q   <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= tick ? TMR_INIT : timer_q - 1'b1;
      // Requests arriving while busy collapse into this single flag.
      pend_q  <= enter_wr ? 1'b0 : (pend_q | tick | i_trigger);

      if ((state_q == IDLE) || (state_d != state_q)) tmo_q <= '0;
      else                                           tmo_q <= tmo_q + 1'b1;

      // Bus outputs are decoded from the next state so they appear registered.
      cyc_q  <= (state_d != IDLE);
      busy_q <= (state_d != IDLE);
      stb_q  <= (state_d == WR_REQ) || (state_d == RD_REQ);
      we_q   <= (state_d == WR_REQ);

      if (enter_wr) begin
        data_q <= seq_q;
        err_q  <= 1'b0;
      end
      if (timeout) err_q <= 1'b1;
      if ((state_q == WR_REQ) && (state_d == WR_ACK)) seq_q <= seq_q + 6'd1;
      if ((state_q == RD_ACK) && wb.i_ack) rdata_q <= wb.i_data;
    end
  end

  assign wb.o_cyc  = cyc_q;
  assign wb.o_stb  = stb_q;
  assign wb.o_we   = we_q;
  assign wb.o_addr = 1'b0;
  assign wb.o_data = data_q;
  assign o_busy    = busy_q;
  assign o_err     = err_q;
  assign o_rdata   = rdata_q;

endmodule

// File: tb/tb_wbwalker_master.sv
// Directed bench for wbwalker_master: scoreboarded write data, bus timing, timeout, reset and tick behaviour.
// Instance a runs the trigger-driven cases, instance b (PERIOD=20) the free-running tick case.
module tb_wbwalker_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_n  = 0;
  always @(posedge clk) cyc_n++;

  // ---------------- instance a ----------------
  logic       a_rst = 1'b1;
  logic       a_trig = 1'b0;
  logic       a_stall = 1'b0;
  logic       block_wr = 1'b0;
  logic [5:0] rd_val = 6'h01;
  logic       a_busy, a_err;
  logic [5:0] a_rdata;
  wbwalker_master_if a_wb();

  wbwalker_master #(.PERIOD(1000), .TIMEOUT(15)) dut_a (
    .i_clk(clk), .i_reset(a_rst), .i_trigger(a_trig),
    .o_busy(a_busy), .o_err(a_err), .o_rdata(a_rdata), .wb(a_wb)
  );

  assign a_wb.i_stall = a_stall;
  assign a_wb.i_data  = rd_val;
  always @(posedge clk)
    a_wb.i_ack <= a_wb.o_cyc && a_wb.o_stb && !a_wb.i_stall && !(a_wb.o_we && block_wr);

  // ---------------- instance b ----------------
  logic       b_rst = 1'b1;
  logic       b_trig = 1'b0;
  logic       b_busy, b_err;
  logic [5:0] b_rdata;
  wbwalker_master_if b_wb();

  wbwalker_master #(.PERIOD(20), .TIMEOUT(15)) dut_b (
    .i_clk(clk), .i_reset(b_rst), .i_trigger(b_trig),
    .o_busy(b_busy), .o_err(b_err), .o_rdata(b_rdata), .wb(b_wb)
  );

  assign b_wb.i_stall = 1'b0;
  assign b_wb.i_data  = 6'h2a;
  always @(posedge clk)
    b_wb.i_ack <= b_wb.o_cyc && b_wb.o_stb && !b_wb.i_stall;

  // ---------------- checking ----------------
  logic [5:0] exp_a[$];
  logic [5:0] exp_b[$];
  int         b_start_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instance a monitor: CYC run lengths, low gaps, start count, write-data scoreboard.
  int   a_run = 0, a_low = 0, a_len = 0, a_gap = 0, a_starts = 0;
  logic a_cyc_prev = 1'b0;
  always @(negedge clk) begin
    if (a_wb.o_cyc === 1'b1) begin
      if (!a_cyc_prev) begin
        a_starts++;
        a_gap = a_low;
      end
      a_run++;
      a_low = 0;
    end else begin
      if (a_cyc_prev) a_len = a_run;
      a_run = 0;
      a_low++;
    end
    a_cyc_prev = (a_wb.o_cyc === 1'b1);
    if (a_wb.o_cyc === 1'b1 && a_wb.o_stb === 1'b1 && a_wb.o_we === 1'b1 && !a_wb.i_stall) begin
      chk("a_wr_expected", exp_a.size() != 0, 1);
      if (exp_a.size() != 0) chk("a_wr_data", a_wb.o_data, exp_a.pop_front());
    end
  end

  logic b_cyc_prev = 1'b0;
  always @(negedge clk) begin
    if (b_wb.o_cyc === 1'b1 && !b_cyc_prev) b_start_cyc.push_back(cyc_n);
    b_cyc_prev = (b_wb.o_cyc === 1'b1);
    if (b_wb.o_cyc === 1'b1 && b_wb.o_stb === 1'b1 && b_wb.o_we === 1'b1) begin
      chk("b_wr_expected", exp_b.size() != 0, 1);
      if (exp_b.size() != 0) chk("b_wr_data", b_wb.o_data, exp_b.pop_front());
    end
  end

  task automatic pulse_a();
    @(posedge clk); #1 a_trig = 1'b1;
    @(posedge clk); #1 a_trig = 1'b0;
  endtask

  task automatic wait_idle_a(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while (a_busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk(tag, a_busy, 0);
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_cyc"},   a_wb.o_cyc,  0);
    chk({tag, "_stb"},   a_wb.o_stb,  0);
    chk({tag, "_we"},    a_wb.o_we,   0);
    chk({tag, "_addr"},  a_wb.o_addr, 0);
    chk({tag, "_data"},  a_wb.o_data, 0);
    chk({tag, "_busy"},  a_busy,      0);
    chk({tag, "_err"},   a_err,       0);
    chk({tag, "_rdata"}, a_rdata,     0);
  endtask

  initial begin
    int s0;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1 a_rst = 1'b0;
    @(negedge clk);
    chk_zero_a("reset");

    // Single transaction, zero-stall slave
    exp_a.push_back(6'd0);
    pulse_a();
    @(negedge clk);
    chk("t1_start_cyc", a_wb.o_cyc, 1);
    chk("t1_start_stb", a_wb.o_stb, 1);
    chk("t1_start_we",  a_wb.o_we,  1);
    wait_idle_a("t1_done", 20);
    chk("t1_cyc_len", a_len, 4);
    chk("t1_rdata", a_rdata, 6'h01);
    chk("t1_err", a_err, 0);

    // Five stall cycles in the write request
    rd_val  = 6'h15;
    a_stall = 1'b1;
    exp_a.push_back(6'd1);
    pulse_a();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_stall_stb",  a_wb.o_stb,  1);
      chk("t2_stall_we",   a_wb.o_we,   1);
      chk("t2_stall_data", a_wb.o_data, 6'd1);
      @(posedge clk); #1;
    end
    a_stall = 1'b0;
    wait_idle_a("t2_done", 20);
    chk("t2_rdata", a_rdata, 6'h15);
    chk("t2_err", a_err, 0);

    // Write never acked: abort after TIMEOUT cycles in WR_ACK
    block_wr = 1'b1;
    exp_a.push_back(6'd2);
    pulse_a();
    wait_idle_a("t3_done", 40);
    chk("t3_cyc_len", a_len, 16);
    chk("t3_cyc", a_wb.o_cyc, 0);
    chk("t3_err", a_err, 1);
    chk("t3_rdata_kept", a_rdata, 6'h15);
    block_wr = 1'b0;
    repeat (2) @(negedge clk);
    chk("t3_err_sticky", a_err, 1);
    exp_a.push_back(6'd3);
    pulse_a();
    @(negedge clk);
    chk("t3_err_clear", a_err, 0);
    chk("t3_restart_cyc", a_wb.o_cyc, 1);
    wait_idle_a("t3_retry_done", 20);
    chk("t3_retry_err", a_err, 0);

    // Three triggers during one busy transaction collapse to one follow-on
    s0 = a_starts;
    a_stall = 1'b1;
    exp_a.push_back(6'd4);
    exp_a.push_back(6'd5);
    pulse_a();
    repeat (3) pulse_a();
    a_stall = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("t4_starts", a_starts - s0, 2);
    chk("t4_gap", a_gap, 1);
    chk("t4_idle", a_busy, 0);
    chk("t4_queue_empty", exp_a.size(), 0);

    // Reset while in RD_REQ
    exp_a.push_back(6'd6);
    pulse_a();
    n = 0;
    @(negedge clk);
    while (!(a_wb.o_cyc === 1'b1 && a_wb.o_stb === 1'b1 && a_wb.o_we === 1'b0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_rd_req", n < 20, 1);
    a_rst = 1'b1;
    @(negedge clk);
    chk_zero_a("t6_reset");
    a_rst = 1'b0;
    rd_val = 6'h2c;
    exp_a.push_back(6'd0);
    pulse_a();
    wait_idle_a("t6_done", 20);
    chk("t6_rdata", a_rdata, 6'h2c);
    chk("t6_queue_empty", exp_a.size(), 0);

    // Free-running tick, PERIOD=20, no trigger
    for (int i = 0; i < 10; i++) exp_b.push_back(6'(i));
    @(posedge clk); #1 b_rst = 1'b0;
    repeat (210) @(posedge clk);
    #1 b_rst = 1'b1;
    @(negedge clk);
    chk("t5_starts", b_start_cyc.size(), 10);
    for (int i = 1; i < b_start_cyc.size(); i++)
      chk("t5_spacing", b_start_cyc[i] - b_start_cyc[i-1], 20);
    chk("t5_queue_empty", exp_b.size(), 0);
    chk("t5_rdata", b_rdata, 6'h2a);
    chk("t5_err", b_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
